// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the ALU issue sequencer: ALU control codes,
// opcode/funct7 constants, sequencer states and the decode bundle.
package rv32i_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLTU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        use_imm;
    logic        is_shift;
    logic        is_slt;
    logic        illegal;
    logic [31:0] imm;
  } decode_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of an RV32I OP / OP-IMM word into ALU control,
// operand-select flags, the sign-extended immediate and an illegal flag.
module alu_issue_decode
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_imm;
  logic       legal;
  logic [9:0] unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign is_op         = (opcode == OPC_OP);
  assign is_imm        = (opcode == OPC_OP_IMM);
  assign unused_fields = {instr[19:15], instr[11:7]};

  always_comb begin
    // NOTE: every output gets a default up front so no path can infer a latch.
    dec         = '0;
    dec.imm     = {{20{instr[31]}}, instr[31:20]};
    dec.use_imm = is_imm;
    legal       = is_op | is_imm;

    case (funct3)
      3'b000: begin
        if (is_op && funct7 == F7_ALT) begin
          dec.ctrl = ALU_SUB;
        end else begin
          dec.ctrl = ALU_ADD;
          if (is_op && funct7 != F7_BASE) legal = 1'b0;
        end
      end
      3'b001: begin
        dec.ctrl     = ALU_SLL;
        dec.is_shift = 1'b1;
        if (funct7 != F7_BASE) legal = 1'b0;
      end
      3'b010: begin
        dec.ctrl   = ALU_SLTU;
        dec.is_slt = 1'b1;
      end
      3'b011: dec.ctrl = ALU_SLTU;
      3'b100: begin
        dec.ctrl = ALU_XOR;
        if (is_op && funct7 != F7_BASE) legal = 1'b0;
      end
      3'b101: begin
        dec.is_shift = 1'b1;
        if (funct7 == F7_BASE)     dec.ctrl = ALU_SRL;
        else if (funct7 == F7_ALT) dec.ctrl = ALU_SRA;
        else                       legal    = 1'b0;
      end
      3'b110: begin
        dec.ctrl = ALU_OR;
        if (is_op && funct7 != F7_BASE) legal = 1'b0;
      end
      3'b111: begin
        dec.ctrl = ALU_AND;
        if (is_op && funct7 != F7_BASE) legal = 1'b0;
      end
      default: dec.ctrl = ALU_ADD;
    endcase

    // Illegal words run as a harmless ADD so the timing stays uniform.
    if (!legal) begin
      dec.ctrl     = ALU_ADD;
      dec.is_shift = 1'b0;
      dec.is_slt   = 1'b0;
    end
    dec.illegal = ~legal;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer driving an RV32I ALU: IDLE -> EXEC -> WB.
// Optional `ALU_ISSUE_ILLEGAL_TRAP_EN` makes `illegal` pulse in WB of a bad word.
module alu_issue
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_less,
  input  logic        alu_zero,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        illegal
);

  state_t      state, state_next;
  decode_t     dec;
  logic [31:0] b_sel;
  logic [31:0] sign_flip;
  logic        accept;
  logic        is_cmp_q;
  logic        illegal_q;
  logic        status_zero_unused;

  alu_issue_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  assign accept = (state == IDLE) & instr_valid;

  // SLT runs on the unsigned comparator with both sign bits inverted.
  assign sign_flip = {dec.is_slt, 31'b0};

  always_comb begin
    b_sel = dec.use_imm ? dec.imm : rs2_data;
    if (dec.is_shift) b_sel = {27'b0, b_sel[4:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    rd_we       = (state == WB) && !illegal_q && (rd_addr != 5'd0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    illegal     = (state == WB) && illegal_q;
`else
    illegal     = 1'b0;
`endif
  end

  // Datapath registers are reset because they drive visible outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a              <= '0;
      alu_b              <= '0;
      alu_ctrl           <= ALU_ADD;
      rd_addr            <= '0;
      rd_data            <= '0;
      is_cmp_q           <= 1'b0;
      illegal_q          <= 1'b0;
      status_zero_unused <= 1'b0;
    end else begin
      if (accept) begin
        alu_a     <= rs1_data ^ sign_flip;
        alu_b     <= b_sel ^ sign_flip;
        alu_ctrl  <= dec.ctrl;
        rd_addr   <= instr[11:7];
        is_cmp_q  <= (dec.ctrl == ALU_SLTU);
        illegal_q <= dec.illegal;
      end
      if (state == EXEC) begin
        rd_data            <= is_cmp_q ? {31'b0, alu_less} : alu_result;
        status_zero_unused <= alu_zero;
      end
    end
  end

endmodule
